// File: rtl/bram_mem_arb.sv
// bram_mem_arb: arbitrates the single 16-bit backup-RAM SRAM port between
// the 8-bit serial-EEPROM core (port A, byte accesses) and the 16-bit
// MCU/save-state side (port B, word or byte-lane accesses).
// Each access runs as a strobe window (ACC_CYC cycles), then one CE-hold
// cycle carrying the ack pulse.
// Optional feature: define BRAM_ARB_FIXPRI_EN to make port B win every tie.
// Without it, ties are resolved round-robin.
module bram_mem_arb #(
  parameter int unsigned ACC_CYC = 4,
  parameter int unsigned B_AW    = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [15:0]     a_addr,
  input  logic [7:0]      a_di,
  output logic [7:0]      a_do,
  output logic            a_ack,
  input  logic            b_req,
  input  logic            b_we_lo,
  input  logic            b_we_hi,
  input  logic [B_AW-1:0] b_addr,
  input  logic [15:0]     b_di,
  output logic [15:0]     b_do,
  output logic            b_ack,
  input  logic [15:0]     mem_do,
  output logic [15:0]     mem_di,
  output logic [B_AW-1:0] mem_addr,
  output logic            mem_ce,
  output logic            mem_oe,
  output logic            mem_we_lo,
  output logic            mem_we_hi,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            pend_a, pend_b;
  logic            last_b;
  logic            gnt_b;
  logic            pick_b;
  logic            clr_a, clr_b;

  logic            a_we_q;
  logic [15:0]     a_addr_q;
  logic [7:0]      a_di_q;
  logic            b_we_lo_q, b_we_hi_q;
  logic [B_AW-1:0] b_addr_q;
  logic [15:0]     b_di_q;

  // Pending flags clear on the cycle that leaves HOLD, so a request landing in
  // the ack cycle is seen as a fresh command.
  assign clr_a = (state == HOLD) && !gnt_b;
  assign clr_b = (state == HOLD) &&  gnt_b;
  assign busy  = (state != IDLE) || pend_a || pend_b;

  // Grant selection for the next access.
  always_comb begin
    pick_b = 1'b0;
`ifdef BRAM_ARB_FIXPRI_EN
    pick_b = pend_b;
`else
    pick_b = pend_b && (!pend_a || !last_b);
`endif
  end

  // Request capture: the first command is kept until its own ack; a set wins
  // over the clear in the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      a_we_q    <= 1'b0;
      a_addr_q  <= '0;
      a_di_q    <= '0;
      b_we_lo_q <= 1'b0;
      b_we_hi_q <= 1'b0;
      b_addr_q  <= '0;
      b_di_q    <= '0;
    end else begin
      if (a_req && (!pend_a || clr_a)) begin
        pend_a   <= 1'b1;
        a_we_q   <= a_we;
        a_addr_q <= a_addr;
        a_di_q   <= a_di;
      end else if (clr_a) begin
        pend_a <= 1'b0;
      end
      if (b_req && (!pend_b || clr_b)) begin
        pend_b    <= 1'b1;
        b_we_lo_q <= b_we_lo;
        b_we_hi_q <= b_we_hi;
        b_addr_q  <= b_addr;
        b_di_q    <= b_di;
      end else if (clr_b) begin
        pend_b <= 1'b0;
      end
    end
  end

  // Access sequencer with registered SRAM strobes, read-data latches and acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_b    <= 1'b1;
      gnt_b     <= 1'b0;
      a_do      <= '0;
      b_do      <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      mem_di    <= '0;
      mem_addr  <= '0;
      mem_ce    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_we_lo <= 1'b0;
      mem_we_hi <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_ack  <= 1'b0;
          b_ack  <= 1'b0;
          mem_ce <= 1'b0;
          if (pend_a || pend_b) begin
            state  <= ACC;
            cnt    <= '0;
            gnt_b  <= pick_b;
            mem_ce <= 1'b1;
            if (pick_b) begin
              mem_addr  <= b_addr_q;
              mem_di    <= b_di_q;
              mem_oe    <= !(b_we_lo_q || b_we_hi_q);
              mem_we_lo <= b_we_lo_q;
              mem_we_hi <= b_we_hi_q;
            end else begin
              mem_addr  <= {{(B_AW-15){1'b0}}, a_addr_q[15:1]};
              mem_di    <= {a_di_q, a_di_q};
              mem_oe    <= !a_we_q;
              mem_we_lo <= a_we_q &&  a_addr_q[0];
              mem_we_hi <= a_we_q && !a_addr_q[0];
            end
          end
        end
        ACC: begin
          if (cnt == 4'(ACC_CYC - 1)) begin
            state     <= HOLD;
            mem_oe    <= 1'b0;
            mem_we_lo <= 1'b0;
            mem_we_hi <= 1'b0;
            if (gnt_b) begin
              b_ack <= 1'b1;
              if (mem_oe) b_do <= mem_do;
            end else begin
              a_ack <= 1'b1;
              if (mem_oe) a_do <= a_addr_q[0] ? mem_do[7:0] : mem_do[15:8];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          state  <= IDLE;
          a_ack  <= 1'b0;
          b_ack  <= 1'b0;
          mem_ce <= 1'b0;
          last_b <= gnt_b;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_mem_arb.sv
// tb_bram_mem_arb: directed stimulus with a queue-based scoreboard; the
// monitor checks SRAM access setup and ack data/timing against expectations.
module tb_bram_mem_arb;
  localparam int unsigned ACC_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we;
  logic [15:0] a_addr;
  logic [7:0]  a_di, a_do;
  logic        a_ack;
  logic        b_req, b_we_lo, b_we_hi;
  logic [18:0] b_addr;
  logic [15:0] b_di, b_do;
  logic        b_ack;
  logic [15:0] mem_do, mem_di;
  logic [18:0] mem_addr;
  logic        mem_ce, mem_oe, mem_we_lo, mem_we_hi, busy;

  always #5 clk = ~clk;

  bram_mem_arb #(.ACC_CYC(ACC_CYC), .B_AW(19)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_di(a_di), .a_do(a_do), .a_ack(a_ack),
    .b_req(b_req), .b_we_lo(b_we_lo), .b_we_hi(b_we_hi), .b_addr(b_addr), .b_di(b_di),
    .b_do(b_do), .b_ack(b_ack),
    .mem_do(mem_do), .mem_di(mem_di), .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_oe(mem_oe),
    .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi), .busy(busy)
  );

  typedef struct { logic [15:0] d; int unsigned cyc; } ack_t;
  typedef struct { logic [18:0] addr; logic [15:0] di; logic oe; logic wlo; logic whi; } acc_t;

  ack_t aq[$];
  ack_t bq[$];
  acc_t mq[$];

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: event occurred with nothing expected", nm);
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack or starts an access.
  logic        prev_ce = 1'b0;
  logic [18:0] lat_addr;
  logic [15:0] lat_di;
  ack_t        ea, eb;
  acc_t        em;
  always @(negedge clk) begin
    if (a_ack) begin
      if (aq.size() == 0) flag("a_ack_extra");
      else begin
        ea = aq.pop_front();
        chk("a_do", {24'h0, a_do}, {16'h0, ea.d});
        chk("a_ack_cycle", cyc, ea.cyc);
      end
    end
    if (b_ack) begin
      if (bq.size() == 0) flag("b_ack_extra");
      else begin
        eb = bq.pop_front();
        chk("b_do", {16'h0, b_do}, {16'h0, eb.d});
        chk("b_ack_cycle", cyc, eb.cyc);
      end
    end
    if (mem_ce && !prev_ce) begin
      if (mq.size() == 0) flag("mem_access_extra");
      else begin
        em = mq.pop_front();
        chk("mem_addr", {13'h0, mem_addr}, {13'h0, em.addr});
        chk("mem_di", {16'h0, mem_di}, {16'h0, em.di});
        chk("mem_oe", {31'h0, mem_oe}, {31'h0, em.oe});
        chk("mem_we_lo", {31'h0, mem_we_lo}, {31'h0, em.wlo});
        chk("mem_we_hi", {31'h0, mem_we_hi}, {31'h0, em.whi});
      end
      lat_addr = mem_addr;
      lat_di   = mem_di;
    end else if (mem_ce && prev_ce) begin
      chk("addr_stable", {13'h0, mem_addr}, {13'h0, lat_addr});
      chk("di_stable", {16'h0, mem_di}, {16'h0, lat_di});
    end
    prev_ce = mem_ce;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_a(input logic we, input logic [15:0] addr, input logic [7:0] di,
                         output int unsigned n);
    @(negedge clk);
    a_req = 1'b1; a_we = we; a_addr = addr; a_di = di;
    n = cyc + 1;
    @(negedge clk);
    a_req = 1'b0;
  endtask

  task automatic drive_b(input logic wlo, input logic whi, input logic [18:0] addr,
                         input logic [15:0] di, output int unsigned n);
    @(negedge clk);
    b_req = 1'b1; b_we_lo = wlo; b_we_hi = whi; b_addr = addr; b_di = di;
    n = cyc + 1;
    @(negedge clk);
    b_req = 1'b0;
  endtask

  task automatic count_strobes(output int unsigned oe_n, output int unsigned wl_n,
                               output int unsigned wh_n);
    oe_n = 0; wl_n = 0; wh_n = 0;
    for (int i = 0; i < 8; i++) begin
      oe_n += int'(mem_oe);
      wl_n += int'(mem_we_lo);
      wh_n += int'(mem_we_hi);
      @(negedge clk);
    end
  endtask

  int unsigned n, oe_n, wl_n, wh_n;

  initial begin
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_di = 0;
    b_req = 0; b_we_lo = 0; b_we_hi = 0; b_addr = 0; b_di = 0;
    mem_do = 16'h0000;
    do_reset();

    // Reset state
    chk("rst_a_do", {24'h0, a_do}, 32'h0);
    chk("rst_b_do", {16'h0, b_do}, 32'h0);
    chk("rst_acks", {30'h0, a_ack, b_ack}, 32'h0);
    chk("rst_mem_ctl", {28'h0, mem_ce, mem_oe, mem_we_lo, mem_we_hi}, 32'h0);
    chk("rst_mem_addr", {13'h0, mem_addr}, 32'h0);
    chk("rst_mem_di", {16'h0, mem_di}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // 1: A byte write to the low lane on an idle bus
    drive_a(1'b1, 16'h0003, 8'h5A, n);
    mq.push_back('{addr: 19'h00001, di: 16'h5A5A, oe: 1'b0, wlo: 1'b1, whi: 1'b0});
    aq.push_back('{d: 16'h0000, cyc: n + 5});
    chk("t1_busy", {31'h0, busy}, 32'h1);
    count_strobes(oe_n, wl_n, wh_n);
    chk("t1_we_lo_cycles", wl_n, 32'd4);
    chk("t1_we_hi_cycles", wh_n, 32'd0);
    chk("t1_oe_cycles", oe_n, 32'd0);

    // 2: A byte read of the high lane
    mem_do = 16'hA55A;
    drive_a(1'b0, 16'h0002, 8'h00, n);
    mq.push_back('{addr: 19'h00001, di: 16'h0000, oe: 1'b1, wlo: 1'b0, whi: 1'b0});
    aq.push_back('{d: 16'h00A5, cyc: n + 5});
    count_strobes(oe_n, wl_n, wh_n);
    chk("t2_oe_cycles", oe_n, ACC_CYC);
    chk("t2_we_cycles", wl_n + wh_n, 32'd0);
    chk("t2_busy_idle", {31'h0, busy}, 32'h0);

    // 3: simultaneous A and B reads after reset
    do_reset();
    @(negedge clk);
    mem_do = 16'hC33C;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0005; a_di = 8'h00;
    b_req = 1'b1; b_we_lo = 1'b0; b_we_hi = 1'b0; b_addr = 19'h12345; b_di = 16'h0000;
    n = cyc + 1;
`ifdef BRAM_ARB_FIXPRI_EN
    mq.push_back('{addr: 19'h12345, di: 16'h0000, oe: 1'b1, wlo: 1'b0, whi: 1'b0});
    mq.push_back('{addr: 19'h00002, di: 16'h0000, oe: 1'b1, wlo: 1'b0, whi: 1'b0});
    bq.push_back('{d: 16'hC33C, cyc: n + 5});
    aq.push_back('{d: 16'h003C, cyc: n + 11});
`else
    mq.push_back('{addr: 19'h00002, di: 16'h0000, oe: 1'b1, wlo: 1'b0, whi: 1'b0});
    mq.push_back('{addr: 19'h12345, di: 16'h0000, oe: 1'b1, wlo: 1'b0, whi: 1'b0});
    aq.push_back('{d: 16'h003C, cyc: n + 5});
    bq.push_back('{d: 16'hC33C, cyc: n + 11});
`endif
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    repeat (14) @(negedge clk);

    // 4a: second B pulse mid-access is ignored
    drive_b(1'b1, 1'b1, 19'h7FFFF, 16'h1234, n);
    mq.push_back('{addr: 19'h7FFFF, di: 16'h1234, oe: 1'b0, wlo: 1'b1, whi: 1'b1});
    bq.push_back('{d: 16'hC33C, cyc: n + 5});
    @(negedge clk);
    b_req = 1'b1; b_we_lo = 1'b1; b_we_hi = 1'b0; b_addr = 19'h00000; b_di = 16'hFFFF;
    @(negedge clk);
    b_req = 1'b0;
    repeat (12) @(negedge clk);

    // 4b: second B pulse in the ack cycle starts a new access
    drive_b(1'b1, 1'b1, 19'h7FFFF, 16'h1234, n);
    mq.push_back('{addr: 19'h7FFFF, di: 16'h1234, oe: 1'b0, wlo: 1'b1, whi: 1'b1});
    bq.push_back('{d: 16'hC33C, cyc: n + 5});
    repeat (5) @(negedge clk);
    chk("t4b_ack_cycle_seen", {31'h0, b_ack}, 32'h1);
    b_req = 1'b1; b_we_lo = 1'b1; b_we_hi = 1'b0; b_addr = 19'h00010; b_di = 16'hBEEF;
    mq.push_back('{addr: 19'h00010, di: 16'hBEEF, oe: 1'b0, wlo: 1'b1, whi: 1'b0});
    bq.push_back('{d: 16'hC33C, cyc: n + 11});
    @(negedge clk);
    b_req = 1'b0;
    repeat (12) @(negedge clk);

    // 5: reset on the second ACC cycle of a B write
    drive_b(1'b1, 1'b1, 19'h00ABC, 16'h0F0F, n);
    mq.push_back('{addr: 19'h00ABC, di: 16'h0F0F, oe: 1'b0, wlo: 1'b1, whi: 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_mem_ce", {31'h0, mem_ce}, 32'h0);
    chk("t5_mem_we", {30'h0, mem_we_lo, mem_we_hi}, 32'h0);
    chk("t5_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_busy_after", {31'h0, busy}, 32'h0);
    chk("t5_b_do_cleared", {16'h0, b_do}, 32'h0);

    chk("aq_drained", aq.size(), 32'd0);
    chk("bq_drained", bq.size(), 32'd0);
    chk("mq_drained", mq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
